// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register family: reset and
// write-enable constants, default NOP codes, default bus widths, and the
// per-cycle pipeline action type.
package id_ex_pipe_pkg;

    localparam logic RstEnable    = 1'b0;
    localparam logic WriteDisable = 1'b0;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned ALUOP_W_DEF    = 8;
    localparam int unsigned ALUSEL_W_DEF   = 3;

    localparam int unsigned NOP_ALUOP_DEF  = 0;
    localparam int unsigned NOP_ALUSEL_DEF = 0;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } pipe_act_e;

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use comparator: requests a decode stall when the
// instruction in EX is a valid load writing a register that decode reads.
module id_ex_hazard #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic                  ex_we,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  id_re0,
    input  logic [REG_ADDR_W-1:0] id_raddr0,
    input  logic                  id_re1,
    input  logic [REG_ADDR_W-1:0] id_raddr1,
    output logic                  stallreq
);

    logic producer_live;
    logic match0;
    logic match1;

    // Flag a stall when a live load producer matches either decode read port
    always_comb begin
        producer_live = ex_valid && ex_is_load && ex_we && (ex_waddr != '0);
        match0        = id_re0 && (id_raddr0 == ex_waddr);
        match1        = id_re1 && (id_raddr1 == ex_waddr);
        stallreq      = producer_live && (match0 || match1);
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with stall/flush/bubble control, EX valid bit
// and load-use hazard detection.
// Optional feature macro: ID_EX_PERF_EN adds saturating perf_bubbles and
// perf_holds counters as output ports.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int unsigned           DATA_W     = DATA_W_DEF,
    parameter int unsigned           REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned           ALUOP_W    = ALUOP_W_DEF,
    parameter int unsigned           ALUSEL_W   = ALUSEL_W_DEF,
    parameter logic [ALUOP_W-1:0]    NOP_ALUOP  = ALUOP_W'(NOP_ALUOP_DEF),
    parameter logic [ALUSEL_W-1:0]   NOP_ALUSEL = ALUSEL_W'(NOP_ALUSEL_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_id,
    input  logic                  stall_ex,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [ALUOP_W-1:0]    id_aluop,
    input  logic [ALUSEL_W-1:0]   id_alusel,
    input  logic [DATA_W-1:0]     id_reg0,
    input  logic [DATA_W-1:0]     id_reg1,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic [DATA_W-1:0]     id_link_addr,
    input  logic                  id_is_in_delayslot,
    input  logic                  next_inst_in_delayslot,
    input  logic                  id_re0,
    input  logic                  id_re1,
    input  logic [REG_ADDR_W-1:0] id_raddr0,
    input  logic [REG_ADDR_W-1:0] id_raddr1,
    output logic                  ex_valid,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [ALUSEL_W-1:0]   ex_alusel,
    output logic [DATA_W-1:0]     ex_reg0,
    output logic [DATA_W-1:0]     ex_reg1,
    output logic [REG_ADDR_W-1:0] ex_waddr,
    output logic                  ex_we,
    output logic                  ex_is_load,
    output logic [DATA_W-1:0]     ex_link_addr,
    output logic                  ex_is_in_delayslot,
    output logic                  is_in_delayslot_o,
    output logic                  stallreq_loaduse
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]           perf_bubbles,
    output logic [31:0]           perf_holds
`endif
);

    pipe_act_e act;

    logic                  ex_valid_q, ex_valid_d;
    logic [ALUOP_W-1:0]    ex_aluop_q, ex_aluop_d;
    logic [ALUSEL_W-1:0]   ex_alusel_q, ex_alusel_d;
    logic [DATA_W-1:0]     ex_reg0_q, ex_reg0_d;
    logic [DATA_W-1:0]     ex_reg1_q, ex_reg1_d;
    logic [REG_ADDR_W-1:0] ex_waddr_q, ex_waddr_d;
    logic                  ex_we_q, ex_we_d;
    logic                  ex_is_load_q, ex_is_load_d;
    logic [DATA_W-1:0]     ex_link_addr_q, ex_link_addr_d;
    logic                  ex_ds_q, ex_ds_d;
    logic                  ds_o_q, ds_o_d;

    // Resolve the per-cycle action; stall_ex alone (illegal) falls into hold
    always_comb begin
        if (flush)         act = ACT_FLUSH;
        else if (stall_ex) act = ACT_HOLD;
        else if (stall_id) act = ACT_BUBBLE;
        else               act = ACT_LOAD;
    end

    // Next-state for the EX copies and the fed-back delay-slot flag
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_aluop_d     = ex_aluop_q;
        ex_alusel_d    = ex_alusel_q;
        ex_reg0_d      = ex_reg0_q;
        ex_reg1_d      = ex_reg1_q;
        ex_waddr_d     = ex_waddr_q;
        ex_we_d        = ex_we_q;
        ex_is_load_d   = ex_is_load_q;
        ex_link_addr_d = ex_link_addr_q;
        ex_ds_d        = ex_ds_q;
        ds_o_d         = ds_o_q;
        case (act)
            ACT_LOAD: begin
                ex_valid_d     = id_valid;
                ex_aluop_d     = id_aluop;
                ex_alusel_d    = id_alusel;
                ex_reg0_d      = id_reg0;
                ex_reg1_d      = id_reg1;
                ex_waddr_d     = id_waddr;
                ex_we_d        = id_we;
                ex_is_load_d   = id_is_load;
                ex_link_addr_d = id_link_addr;
                ex_ds_d        = id_is_in_delayslot;
                ds_o_d         = next_inst_in_delayslot;
            end
            ACT_BUBBLE, ACT_FLUSH: begin
                ex_valid_d     = 1'b0;
                ex_aluop_d     = NOP_ALUOP;
                ex_alusel_d    = NOP_ALUSEL;
                ex_reg0_d      = '0;
                ex_reg1_d      = '0;
                ex_waddr_d     = '0;
                ex_we_d        = WriteDisable;
                ex_is_load_d   = 1'b0;
                ex_link_addr_d = '0;
                ex_ds_d        = 1'b0;
                if (act == ACT_FLUSH) ds_o_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Pipeline registers with synchronous active-low reset to the bubble
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ex_valid_q     <= 1'b0;
            ex_aluop_q     <= NOP_ALUOP;
            ex_alusel_q    <= NOP_ALUSEL;
            ex_reg0_q      <= '0;
            ex_reg1_q      <= '0;
            ex_waddr_q     <= '0;
            ex_we_q        <= WriteDisable;
            ex_is_load_q   <= 1'b0;
            ex_link_addr_q <= '0;
            ex_ds_q        <= 1'b0;
            ds_o_q         <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_aluop_q     <= ex_aluop_d;
            ex_alusel_q    <= ex_alusel_d;
            ex_reg0_q      <= ex_reg0_d;
            ex_reg1_q      <= ex_reg1_d;
            ex_waddr_q     <= ex_waddr_d;
            ex_we_q        <= ex_we_d;
            ex_is_load_q   <= ex_is_load_d;
            ex_link_addr_q <= ex_link_addr_d;
            ex_ds_q        <= ex_ds_d;
            ds_o_q         <= ds_o_d;
        end
    end

    assign ex_valid           = ex_valid_q;
    assign ex_aluop           = ex_aluop_q;
    assign ex_alusel          = ex_alusel_q;
    assign ex_reg0            = ex_reg0_q;
    assign ex_reg1            = ex_reg1_q;
    assign ex_waddr           = ex_waddr_q;
    assign ex_we              = ex_we_q;
    assign ex_is_load         = ex_is_load_q;
    assign ex_link_addr       = ex_link_addr_q;
    assign ex_is_in_delayslot = ex_ds_q;
    assign is_in_delayslot_o  = ds_o_q;

    id_ex_hazard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .ex_valid   (ex_valid_q),
        .ex_is_load (ex_is_load_q),
        .ex_we      (ex_we_q),
        .ex_waddr   (ex_waddr_q),
        .id_re0     (id_re0),
        .id_raddr0  (id_raddr0),
        .id_re1     (id_re1),
        .id_raddr1  (id_raddr1),
        .stallreq   (stallreq_loaduse)
    );

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles_q, perf_bubbles_d;
    logic [31:0] perf_holds_q, perf_holds_d;

    // Saturating increments for bubble and hold cycles
    always_comb begin
        perf_bubbles_d = perf_bubbles_q;
        perf_holds_d   = perf_holds_q;
        if (act == ACT_BUBBLE && perf_bubbles_q != '1) perf_bubbles_d = perf_bubbles_q + 32'd1;
        if (act == ACT_HOLD && perf_holds_q != '1)     perf_holds_d   = perf_holds_q + 32'd1;
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            perf_bubbles_q <= '0;
            perf_holds_q   <= '0;
        end else begin
            perf_bubbles_q <= perf_bubbles_d;
            perf_holds_q   <= perf_holds_d;
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_holds   = perf_holds_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: a reference model of the pipeline
// register compared every cycle, plus hand-computed directed expectations.
`timescale 1ns/1ps
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_id, stall_ex, flush;
    logic        id_valid;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic [31:0] id_reg0, id_reg1;
    logic [4:0]  id_waddr;
    logic        id_we, id_is_load;
    logic [31:0] id_link_addr;
    logic        id_is_in_delayslot, next_inst_in_delayslot;
    logic        id_re0, id_re1;
    logic [4:0]  id_raddr0, id_raddr1;

    logic        ex_valid;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg0, ex_reg1;
    logic [4:0]  ex_waddr;
    logic        ex_we, ex_is_load;
    logic [31:0] ex_link_addr;
    logic        ex_is_in_delayslot, is_in_delayslot_o, stallreq_loaduse;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_bubbles, perf_holds;
`endif

    int checks   = 0;
    int failures = 0;

    id_ex_pipe #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .ALUOP_W    (8),
        .ALUSEL_W   (3),
        .NOP_ALUOP  (8'h00),
        .NOP_ALUSEL (3'b000)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall_id               (stall_id),
        .stall_ex               (stall_ex),
        .flush                  (flush),
        .id_valid               (id_valid),
        .id_aluop               (id_aluop),
        .id_alusel              (id_alusel),
        .id_reg0                (id_reg0),
        .id_reg1                (id_reg1),
        .id_waddr               (id_waddr),
        .id_we                  (id_we),
        .id_is_load             (id_is_load),
        .id_link_addr           (id_link_addr),
        .id_is_in_delayslot     (id_is_in_delayslot),
        .next_inst_in_delayslot (next_inst_in_delayslot),
        .id_re0                 (id_re0),
        .id_re1                 (id_re1),
        .id_raddr0              (id_raddr0),
        .id_raddr1              (id_raddr1),
        .ex_valid               (ex_valid),
        .ex_aluop               (ex_aluop),
        .ex_alusel              (ex_alusel),
        .ex_reg0                (ex_reg0),
        .ex_reg1                (ex_reg1),
        .ex_waddr               (ex_waddr),
        .ex_we                  (ex_we),
        .ex_is_load             (ex_is_load),
        .ex_link_addr           (ex_link_addr),
        .ex_is_in_delayslot     (ex_is_in_delayslot),
        .is_in_delayslot_o      (is_in_delayslot_o),
        .stallreq_loaduse       (stallreq_loaduse)
`ifdef ID_EX_PERF_EN
        ,
        .perf_bubbles           (perf_bubbles),
        .perf_holds             (perf_holds)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one record for the EX stage contents
    typedef struct {
        logic        valid;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg0, reg1;
        logic [4:0]  waddr;
        logic        we, is_load;
        logic [31:0] link;
        logic        ds;
    } ex_rec_t;

    ex_rec_t     m_ex;
    logic        m_dso;
    logic [31:0] m_bub, m_hold;
    bit          m_live = 0;

    function automatic ex_rec_t bubble_rec();
        ex_rec_t r;
        r.valid = 0; r.aluop = 8'h00; r.alusel = 3'b000;
        r.reg0 = 0; r.reg1 = 0; r.waddr = 0; r.we = 0; r.is_load = 0;
        r.link = 0; r.ds = 0;
        return r;
    endfunction

    always @(posedge clk) begin
        ex_rec_t r;
        m_live <= 1;
        if (!rst) begin
            m_ex <= bubble_rec(); m_dso <= 0; m_bub <= 0; m_hold <= 0;
        end else if (flush) begin
            m_ex <= bubble_rec(); m_dso <= 0;
        end else if (stall_ex) begin
            if (m_hold != 32'hFFFF_FFFF) m_hold <= m_hold + 1;
        end else if (stall_id) begin
            m_ex <= bubble_rec();
            if (m_bub != 32'hFFFF_FFFF) m_bub <= m_bub + 1;
        end else begin
            r.valid = id_valid; r.aluop = id_aluop; r.alusel = id_alusel;
            r.reg0 = id_reg0; r.reg1 = id_reg1; r.waddr = id_waddr;
            r.we = id_we; r.is_load = id_is_load; r.link = id_link_addr;
            r.ds = id_is_in_delayslot;
            m_ex <= r; m_dso <= next_inst_in_delayslot;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_live) begin
            logic hz;
            hz = m_ex.valid && m_ex.is_load && m_ex.we && (m_ex.waddr != 0) &&
                 ((id_re0 && id_raddr0 == m_ex.waddr) || (id_re1 && id_raddr1 == m_ex.waddr));
            chk("m_valid",  64'(ex_valid),           64'(m_ex.valid));
            chk("m_aluop",  64'(ex_aluop),           64'(m_ex.aluop));
            chk("m_alusel", 64'(ex_alusel),          64'(m_ex.alusel));
            chk("m_reg0",   64'(ex_reg0),            64'(m_ex.reg0));
            chk("m_reg1",   64'(ex_reg1),            64'(m_ex.reg1));
            chk("m_waddr",  64'(ex_waddr),           64'(m_ex.waddr));
            chk("m_we",     64'(ex_we),              64'(m_ex.we));
            chk("m_load",   64'(ex_is_load),         64'(m_ex.is_load));
            chk("m_link",   64'(ex_link_addr),       64'(m_ex.link));
            chk("m_exds",   64'(ex_is_in_delayslot), 64'(m_ex.ds));
            chk("m_dso",    64'(is_in_delayslot_o),  64'(m_dso));
            chk("m_hazard", 64'(stallreq_loaduse),   64'(hz));
`ifdef ID_EX_PERF_EN
            chk("m_pbub",   64'(perf_bubbles),       64'(m_bub));
            chk("m_phold",  64'(perf_holds),         64'(m_hold));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [7:0] op, input logic [31:0] r0,
                          input logic [4:0] wa, input logic we, input logic ld, input logic nds);
        id_valid = v; id_aluop = op; id_alusel = op[2:0] ^ 3'b101;
        id_reg0 = r0; id_reg1 = ~r0; id_waddr = wa; id_we = we; id_is_load = ld;
        id_link_addr = r0 + 32'h8; id_is_in_delayslot = ~nds; next_inst_in_delayslot = nds;
    endtask

    initial begin
        rst = 0; stall_id = 0; stall_ex = 0; flush = 0;
        id_re0 = 0; id_re1 = 0; id_raddr0 = 0; id_raddr1 = 0;
        set_id(1, 8'h21, 32'hDEAD, 5'd7, 1, 0, 0);

        // Reset for two cycles with live-looking decode inputs
        tick(); tick();
        chk("rst_valid", 64'(ex_valid), 0);
        chk("rst_aluop", 64'(ex_aluop), 0);
        chk("rst_we",    64'(ex_we),    0);
        chk("rst_reg0",  64'(ex_reg0),  0);
        chk("rst_dso",   64'(is_in_delayslot_o), 0);

        // Plain load, one-cycle latency
        rst = 1;
        set_id(1, 8'h25, 32'h1234, 5'd3, 1, 0, 1);
        tick();
        chk("ld_aluop", 64'(ex_aluop), 64'h25);
        chk("ld_reg0",  64'(ex_reg0),  64'h1234);
        chk("ld_waddr", 64'(ex_waddr), 3);
        chk("ld_valid", 64'(ex_valid), 1);
        chk("ld_dso",   64'(is_in_delayslot_o), 1);

        // Hold for three cycles while decode changes
        stall_id = 1; stall_ex = 1;
        set_id(1, 8'h33, 32'h5555, 5'd9, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_aluop", 64'(ex_aluop), 64'h25);
            chk("hold_reg0",  64'(ex_reg0),  64'h1234);
        end

        // One bubble; fed-back delay-slot flag retained
        stall_ex = 0;
        tick();
        chk("bub_valid", 64'(ex_valid), 0);
        chk("bub_we",    64'(ex_we),    0);
        chk("bub_aluop", 64'(ex_aluop), 0);
        chk("bub_dso",   64'(is_in_delayslot_o), 1);

        // Illegal stall_ex-only behaves as hold
        stall_id = 0; stall_ex = 0;
        set_id(1, 8'h44, 32'hA0A0, 5'd4, 1, 0, 0);
        tick();
        stall_ex = 1;
        set_id(1, 8'h55, 32'hB0B0, 5'd6, 1, 0, 0);
        tick();
        chk("illeg_aluop", 64'(ex_aluop), 64'h44);
        stall_ex = 0;

        // Load-use: EX holds a load to r5
        set_id(1, 8'h8C, 32'h100, 5'd5, 1, 1, 0);
        tick();
        id_re1 = 1; id_raddr1 = 5; #1;
        chk("lu_hit_p1", 64'(stallreq_loaduse), 1);
        id_re1 = 0; id_re0 = 1; id_raddr0 = 5; #1;
        chk("lu_hit_p0", 64'(stallreq_loaduse), 1);
        id_re0 = 0; #1;
        chk("lu_noread", 64'(stallreq_loaduse), 0);

        // Load to r0 never hazards
        set_id(1, 8'h8C, 32'h200, 5'd0, 1, 1, 0);
        id_re1 = 0;
        tick();
        id_re1 = 1; id_raddr1 = 0; #1;
        chk("lu_r0", 64'(stallreq_loaduse), 0);

        // Load without writeback never hazards
        id_re1 = 0;
        set_id(1, 8'h8C, 32'h300, 5'd5, 0, 1, 0);
        tick();
        id_re1 = 1; id_raddr1 = 5; #1;
        chk("lu_nowe", 64'(stallreq_loaduse), 0);
        id_re1 = 0;

        // Flush over stall, with a hazard visible before the edge
        set_id(1, 8'h8C, 32'h400, 5'd5, 1, 1, 1);
        tick();
        chk("fl_pre_dso", 64'(is_in_delayslot_o), 1);
        stall_id = 1; stall_ex = 1; flush = 1;
        id_re0 = 1; id_raddr0 = 5; #1;
        chk("fl_hazard", 64'(stallreq_loaduse), 1);
        tick();
        chk("fl_valid", 64'(ex_valid), 0);
        chk("fl_dso",   64'(is_in_delayslot_o), 0);
        chk("fl_exds",  64'(ex_is_in_delayslot), 0);
        chk("fl_hz_after", 64'(stallreq_loaduse), 0);
        flush = 0; id_re0 = 0;

        // A few varied loads
        stall_id = 0; stall_ex = 0;
        for (int i = 0; i < 4; i++) begin
            set_id(i[0], 8'(8'h10 + i), 32'(32'hC000_0000 + i * 17), 5'(i + 8), i[1], i[0], i[1]);
            tick();
        end
        chk("vec_aluop", 64'(ex_aluop), 64'h13);

        // Reset mid-stall, then first load after release
        stall_id = 1; stall_ex = 1; rst = 0;
        tick();
        chk("rstmid_valid", 64'(ex_valid), 0);
        chk("rstmid_aluop", 64'(ex_aluop), 0);
        rst = 1; stall_id = 0; stall_ex = 0;
        set_id(1, 8'h66, 32'h7777, 5'd2, 1, 0, 0);
        tick();
        chk("post_rst_aluop", 64'(ex_aluop), 64'h66);

        // Two bubbles then three holds
        stall_id = 1;
        tick(); tick();
        stall_ex = 1;
        tick(); tick(); tick();
`ifdef ID_EX_PERF_EN
        chk("perf_bub",  64'(perf_bubbles), 2);
        chk("perf_hold", 64'(perf_holds),   3);
`endif
        stall_id = 0; stall_ex = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
